// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan display.
//   SEG_BLANK  : segment pattern with every segment (and dp) off
//   ANODE_OFF  : level that disables one common-anode digit
//   ANODE_ON   : level that enables one common-anode digit
//   hex_to_seg : 4-bit value -> active-low {g,f,e,d,c,b,a}
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic       ANODE_OFF = 1'b1;
  localparam logic       ANODE_ON  = 1'b0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bus bundle between debug taps and the scan display driver.
//   ch_data    : NUM_CH packed hex words, channel c at [c*CH_W +: CH_W]
//   ch_sel     : channel select (out-of-range values show channel 0)
//   freeze     : hold current snapshot
//   blank_lz   : blank leading zero digits
//   anode      : active-low digit enables
//   segment    : active-low {dp,g,f,e,d,c,b,a}
//   frame_tick : one-cycle pulse when a new snapshot is taken
// master = source of channels/controls (debug side), slave = display driver.
interface seg7_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned NUM_CH     = 4
);
  localparam int unsigned CH_W  = 4 * NUM_DIGITS;
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*CH_W-1:0] ch_data;
  logic [SEL_W-1:0]       ch_sel;
  logic                   freeze;
  logic                   blank_lz;
  logic [NUM_DIGITS-1:0]  anode;
  logic [7:0]             segment;
  logic                   frame_tick;

  modport master (
    output ch_data, ch_sel, freeze, blank_lz,
    input  anode, segment, frame_tick
  );

  modport slave (
    input  ch_data, ch_sel, freeze, blank_lz,
    output anode, segment, frame_tick
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder.
//   nibble_i : 4-bit value
//   seg_o    : active-low {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment display driver.
// Scans NUM_DIGITS digits showing a frame-coherent snapshot of one of NUM_CH hex words.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus_io  : slave side of seg7_scan_display_if (channels/controls in, anode/segment/tick out)
// Outputs trail the prescaler/digit counter by exactly two clocks; anode and segment are
// registered in the same stage so they never refer to different digits.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SCAN_DIV_W = 14,
  parameter int unsigned GUARD      = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  seg7_scan_display_if.slave  bus_io
);

  localparam int unsigned CH_W  = 4 * NUM_DIGITS;
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCAN_DIV_W-1:0] PRESC_TC   = '1;
  localparam logic [SCAN_DIV_W-1:0] GUARD_CNT  = SCAN_DIV_W'(GUARD);
  localparam logic [DIG_W-1:0]      LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

  // Scan state
  logic [SCAN_DIV_W-1:0] presc_q, presc_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [CH_W-1:0]       snap_q, snap_d;
  logic                  frame_tick_q, frame_tick_d;

  // Pipeline stage 1
  logic [DIG_W-1:0]      s1_digit_q;
  logic [3:0]            s1_nibble_q;
  logic                  s1_blank_q;
  logic                  s1_guard_q;
  logic                  s1_freeze_q;

  // Pipeline stage 2 (outputs)
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]            segment_q, segment_d;

  logic                  tc;
  logic                  frame_end;
  logic [CH_W-1:0]       ch_word;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            cur_nibble;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  // Channel mux; out-of-range selects fall back to channel 0.
  always_comb begin
    ch_word = bus_io.ch_data[CH_W-1:0];
    for (int c = 1; c < int'(NUM_CH); c++) begin
      if (bus_io.ch_sel == SEL_W'(c)) begin
        ch_word = bus_io.ch_data[c*CH_W +: CH_W];
      end
    end
  end

  assign tc        = (presc_q == PRESC_TC);
  assign frame_end = tc && (digit_q == LAST_DIGIT);

  always_comb begin
    presc_d      = presc_q + SCAN_DIV_W'(1);
    digit_d      = digit_q;
    if (tc) begin
      digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
    end
    // Snapshot only at frame end so a frame is never torn by ch_sel/ch_data changes.
    frame_tick_d = frame_end && !bus_io.freeze;
    snap_d       = frame_tick_d ? ch_word : snap_q;
  end

  // zero_from[k] = nibbles k..NUM_DIGITS-1 of the snapshot are all zero.
  always_comb begin
    zero_from                 = '0;
    zero_from[NUM_DIGITS-1]   = (snap_q[CH_W-1 -: 4] == 4'h0);
    for (int k = int'(NUM_DIGITS) - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (snap_q[4*k +: 4] == 4'h0);
    end
  end

  assign cur_nibble = snap_q[4*int'(digit_q) +: 4];
  // Digit 0 is never blanked, so a zero value still shows a single "0".
  assign cur_blank  = bus_io.blank_lz && (digit_q != '0) && zero_from[digit_q];

  seg7_hex_decode u_hex_decode (
    .nibble_i (s1_nibble_q),
    .seg_o    (dec_seg)
  );

  always_comb begin
    anode_d = {NUM_DIGITS{ANODE_OFF}};
    if (!s1_guard_q) begin
      anode_d[s1_digit_q] = ANODE_ON;
    end
    if (s1_blank_q) begin
      segment_d = SEG_BLANK;
    end else begin
      segment_d = {~(s1_freeze_q && (s1_digit_q == '0)), dec_seg};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      digit_q      <= '0;
      snap_q       <= '0;
      frame_tick_q <= 1'b0;
      s1_digit_q   <= '0;
      s1_nibble_q  <= '0;
      s1_blank_q   <= 1'b0;
      s1_guard_q   <= 1'b1;
      s1_freeze_q  <= 1'b0;
      anode_q      <= {NUM_DIGITS{ANODE_OFF}};
      segment_q    <= SEG_BLANK;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      snap_q       <= snap_d;
      frame_tick_q <= frame_tick_d;
      s1_digit_q   <= digit_q;
      s1_nibble_q  <= cur_nibble;
      s1_blank_q   <= cur_blank;
      s1_guard_q   <= (presc_q < GUARD_CNT);
      s1_freeze_q  <= bus_io.freeze;
      anode_q      <= anode_d;
      segment_q    <= segment_d;
    end
  end

  assign bus_io.anode      = anode_q;
  assign bus_io.segment    = segment_q;
  assign bus_io.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int NC = 4;
  localparam int DIVW = 3;
  localparam int GRD = 2;
  localparam int SLOT = 1 << DIVW;
  localparam int FRAME = SLOT * ND;

  logic clock;
  logic reset_n;

  seg7_scan_display_if #(.NUM_DIGITS(ND), .NUM_CH(NC)) bus ();

  seg7_scan_display #(
    .NUM_DIGITS (ND),
    .NUM_CH     (NC),
    .SCAN_DIV_W (DIVW),
    .GUARD      (GRD)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference scan state (state before the next clock edge).
  int          m_presc;
  int          m_digit;
  logic [15:0] m_snap;
  logic [11:0] exp_q[$];   // {anode, segment} expected two edges later

  logic [7:0] hex_tab [16];

  typedef struct {
    int              ch;
    logic [15:0]     val;
    logic            blz;
    logic [3:0][7:0] exp_seg;  // {digit3, digit2, digit1, digit0}
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_digit = 0;
    m_snap  = 16'h0000;
    exp_q.delete();
  endtask

  // One clock: predict from current state/inputs, advance, compare.
  task automatic step();
    logic [3:0]  ea;
    logic [7:0]  es;
    logic [3:0]  nib;
    logic        blank;
    logic        etick;
    logic [15:0] word;
    logic [11:0] front;
    nib   = m_snap[m_digit*4 +: 4];
    blank = bus.blank_lz && (m_digit > 0) && ((m_snap >> (4 * m_digit)) == 16'h0);
    ea    = (m_presc < GRD) ? 4'hF : ~(4'b0001 << m_digit);
    es    = blank ? 8'hFF : {~(bus.freeze && (m_digit == 0)), hex_tab[nib][6:0]};
    word  = (int'(bus.ch_sel) < NC) ? bus.ch_data[int'(bus.ch_sel)*16 +: 16] : bus.ch_data[15:0];
    etick = (m_presc == SLOT - 1) && (m_digit == ND - 1) && !bus.freeze;
    @(posedge clock);
    #1;
    if (etick) m_snap = word;
    if (m_presc == SLOT - 1) m_digit = (m_digit + 1) % ND;
    m_presc = (m_presc + 1) % SLOT;
    exp_q.push_back({ea, es});
    if (exp_q.size() > 1) begin
      front = exp_q.pop_front();
      check("anode", {28'h0, bus.anode}, {28'h0, front[11:8]});
      check("segment", {24'h0, bus.segment}, {24'h0, front[7:0]});
    end
    check("frame_tick", {31'h0, bus.frame_tick}, {31'h0, etick});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic capture_frame(output logic [3:0][7:0] cap, output int n_guard);
    cap     = '0;
    n_guard = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (bus.anode == 4'hF) n_guard++;
      else begin
        for (int d = 0; d < ND; d++) begin
          if (bus.anode == ~(4'b0001 << d)) cap[d] = bus.segment;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] cap;
    int              ng;
    int              tick_at;
    int              ticks;
    int              found;

    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vecs[0] = '{0, 16'h1234, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{2, 16'hABCD, 1'b0, {8'h88, 8'h83, 8'hC6, 8'hA1}};
    vecs[2] = '{0, 16'h0005, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
    vecs[3] = '{0, 16'h0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4] = '{0, 16'h0005, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'h92}};
    vecs[5] = '{3, 16'h89EF, 1'b1, {8'h80, 8'h90, 8'h86, 8'h8E}};
    vecs[6] = '{0, 16'h0F00, 1'b1, {8'hFF, 8'h8E, 8'hC0, 8'hC0}};

    reset_n      = 1'b0;
    bus.ch_data  = {16'h89EF, 16'hABCD, 16'h5A5A, 16'h1234};
    bus.ch_sel   = 2'd0;
    bus.freeze   = 1'b0;
    bus.blank_lz = 1'b0;
    model_reset();

    // Reset values
    #22;
    check("rst_anode", {28'h0, bus.anode}, 32'hF);
    check("rst_segment", {24'h0, bus.segment}, 32'hFF);
    check("rst_tick", {31'h0, bus.frame_tick}, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // First frame end: edge 32 after release
    tick_at = 0;
    for (int i = 1; i <= FRAME + 8; i++) begin
      step();
      if (bus.frame_tick && tick_at == 0) tick_at = i;
    end
    check("first_tick_edge", tick_at, FRAME);

    // Table-driven display patterns (changes land mid-frame)
    for (int v = 0; v < 7; v++) begin
      bus.ch_data[vecs[v].ch*16 +: 16] = vecs[v].val;
      bus.ch_sel   = 2'(vecs[v].ch);
      bus.blank_lz = vecs[v].blz;
      run(2 * FRAME);
      capture_frame(cap, ng);
      for (int d = 0; d < ND; d++) begin
        check($sformatf("vec%0d_digit%0d", v, d), {24'h0, cap[d]}, {24'h0, vecs[v].exp_seg[d]});
      end
      check($sformatf("vec%0d_guard_cnt", v), ng, GRD * ND);
    end

    // Freeze: snapshot holds, no tick, dp low on digit 0
    bus.ch_data[15:0] = 16'h1234;
    bus.ch_sel        = 2'd0;
    bus.blank_lz      = 1'b0;
    run(2 * FRAME);
    bus.freeze        = 1'b1;
    bus.ch_data[15:0] = 16'hFFFF;
    ticks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.frame_tick) ticks++;
    end
    check("freeze_ticks", ticks, 0);
    capture_frame(cap, ng);
    check("freeze_d0", {24'h0, cap[0]}, 32'h19);
    check("freeze_d1", {24'h0, cap[1]}, 32'hB0);
    check("freeze_d2", {24'h0, cap[2]}, 32'hA4);
    check("freeze_d3", {24'h0, cap[3]}, 32'hF9);
    bus.freeze = 1'b0;
    ticks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.frame_tick) ticks++;
    end
    check("unfreeze_ticks", ticks, 2);
    capture_frame(cap, ng);
    check("unfreeze_d0", {24'h0, cap[0]}, 32'h8E);
    check("unfreeze_d3", {24'h0, cap[3]}, 32'h8E);

    // Reset mid-slot (digit 2, prescaler 4)
    found = 0;
    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      step();
      if (m_presc == 4 && m_digit == 2) found = 1;
    end
    check("mid_slot_reached", found, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_anode", {28'h0, bus.anode}, 32'hF);
    check("midrst_segment", {24'h0, bus.segment}, 32'hFF);
    check("midrst_tick", {31'h0, bus.frame_tick}, 32'h0);
    @(posedge clock);
    #1;
    check("midrst_hold_anode", {28'h0, bus.anode}, 32'hF);
    reset_n = 1'b1;
    model_reset();
    // Edge 4 after release shows prescaler 2 of digit 0, snapshot cleared to 0.
    run(4);
    check("restart_anode", {28'h0, bus.anode}, 32'hE);
    check("restart_segment", {24'h0, bus.segment}, 32'hC0);
    run(FRAME + 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
